// File: rtl/step_dir_gen_pkg.sv
// Shared types and constants for the step/direction generator and its phase timer.
package step_dir_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_PERIOD = 4;
    localparam int DEF_HIGH   = 1;

    // Direction encodings shared with the up/down counter side.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int phase_bits(input int period);
        return (period <= 2) ? 1 : $clog2(period);
    endfunction

endpackage

// File: rtl/step_dir_gen_phase_timer.sv
// Step-period phase counter: registered step level plus a period_end strobe on the last phase.
module step_phase_timer
    import step_dir_gen_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD,
    parameter int HIGH   = DEF_HIGH
) (
    input  logic clk,
    input  logic clear,
    input  logic start_i,
    input  logic run_i,
    output logic step_o,
    output logic period_end_o
);

    localparam int            PW   = phase_bits(PERIOD);
    localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);
    localparam logic [PW-1:0] HI   = PW'(HIGH);

    logic [PW-1:0] phase_q, phase_d;
    logic          step_q, step_d;

    // start wins over run so a new period can begin directly after the last phase.
    always_comb begin
        phase_d = '0;
        step_d  = 1'b0;
        if (start_i) begin
            phase_d = '0;
            step_d  = 1'b1;
        end else if (run_i) begin
            phase_d = phase_q + 1'b1;
            step_d  = (phase_d < HI);
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            phase_q <= '0;
            step_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
        end
    end

    assign step_o       = step_q;
    assign period_end_o = (phase_q == LAST);

endmodule

// File: rtl/step_dir_gen.sv
// Step/direction pulse generator: walks its position register toward a commanded target, one step pulse per count.
module step_dir_gen
    import step_dir_gen_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PERIOD = DEF_PERIOD,
    parameter int HIGH   = DEF_HIGH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    input  logic [WIDTH-1:0] cmd_target,
    output logic             cmd_ready,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic [WIDTH-1:0] position,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             timer_start, timer_run, period_end;
    logic [WIDTH-1:0] next_pos;

    assign next_pos = (dir_q == DIR_UP) ? pos_q + 1'b1 : pos_q - 1'b1;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        tgt_d       = tgt_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        abort_d     = abort_q;
        timer_start = 1'b0;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (cmd_valid) begin
                    tgt_d = cmd_target;
                    if (cmd_target == pos_q) begin
                        done_d = 1'b1;
                    end else begin
                        dir_d   = (cmd_target > pos_q) ? DIR_UP : DIR_DOWN;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                abort_d     = abort_q | abort;
                timer_start = 1'b1;
                pos_d       = next_pos;
                state_d     = STEP;
            end
            STEP: begin
                abort_d = abort_q | abort;
                // Decide only at the end of a full period so no step is truncated.
                if (period_end) begin
                    if (pos_q == tgt_q || abort_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        abort_d = 1'b0;
                    end else begin
                        timer_start = 1'b1;
                        pos_d       = next_pos;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        timer_run = (state_d == STEP) && !timer_start;
        ready_d   = (state_d == IDLE);
        busy_d    = !ready_d;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            dir_q   <= DIR_DOWN;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    step_phase_timer #(
        .PERIOD(PERIOD),
        .HIGH  (HIGH)
    ) u_timer (
        .clk         (clk),
        .clear       (clear),
        .start_i     (timer_start),
        .run_i       (timer_run),
        .step_o      (step),
        .period_end_o(period_end)
    );

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign dir       = dir_q;
    assign position  = pos_q;
    assign done      = done_q;

endmodule

// File: tb/tb_step_dir_gen.sv
// Directed bench for step_dir_gen (WIDTH=8, PERIOD=4, HIGH=1).
module tb_step_dir_gen;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_target = '0;
    logic       abort = 1'b0;
    logic       cmd_ready, step, dir, busy, done;
    logic [7:0] position;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    step_dir_gen #(.WIDTH(8), .PERIOD(4), .HIGH(1)) dut (
        .clk       (clk),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_target(cmd_target),
        .cmd_ready (cmd_ready),
        .abort     (abort),
        .step      (step),
        .dir       (dir),
        .busy      (busy),
        .position  (position),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] t);
        cmd_valid  = 1'b1;
        cmd_target = t;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 200; i++) begin
            tick();
            if (done) break;
        end
        chk(tag, done, 1);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #2 clear = 1'b0;
        #1;
        chk("rst_step", step, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pos", position, 0);
        chk("rst_done", done, 0);
        chk("rst_dir", dir, 0);
        #10 clear = 1'b1;
        tick();
        chk("rst_ready", cmd_ready, 1);

        // Up 0->3 with a rejected command mid-move
        accept(8'd3);
        chk("up_dir", dir, 1);
        chk("up_busy", busy, 1);
        chk("up_ready", cmd_ready, 0);
        chk("up_setup_step", step, 0);
        tick();
        chk("up_s1", step, 1);
        chk("up_p1", position, 1);
        cmd_valid = 1'b1; cmd_target = 8'd7;
        tick();
        cmd_valid = 1'b0;
        chk("up_low", step, 0);
        repeat (3) tick();
        chk("up_s2", step, 1);
        chk("up_p2", position, 2);
        repeat (4) tick();
        chk("up_s3", step, 1);
        chk("up_p3", position, 3);
        repeat (3) tick();
        chk("up_nodone", done, 0);
        tick();
        chk("up_done", done, 1);
        chk("up_done_ready", cmd_ready, 1);
        chk("up_final_pos", position, 3);
        tick();
        chk("up_done_pulse", done, 0);
        chk("rej_idle", busy, 0);

        // Down 3->1
        accept(8'd1);
        chk("dn_dir", dir, 0);
        tick();
        chk("dn_s1", step, 1);
        chk("dn_p1", position, 2);
        repeat (4) tick();
        chk("dn_s2", step, 1);
        chk("dn_p2", position, 1);
        repeat (3) tick();
        chk("dn_nodone", done, 0);
        tick();
        chk("dn_done", done, 1);
        chk("dn_pos", position, 1);

        // Up 1->5, then zero-distance command
        tick();
        accept(8'd5);
        wait_done("to5_done");
        chk("to5_pos", position, 5);
        tick();
        accept(8'd5);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_step", step, 0);
        chk("zero_dir", dir, 1);
        tick();
        chk("zero_pulse", done, 0);

        // Asynchronous reset while step is high
        accept(8'd9);
        tick();
        chk("ar_step_hi", step, 1);
        #2 clear = 1'b0;
        #1;
        chk("ar_step", step, 0);
        chk("ar_pos", position, 0);
        chk("ar_busy", busy, 0);
        #3 clear = 1'b1;
        tick();
        chk("ar_ready", cmd_ready, 1);

        // Abort during the 2nd step's low phase, 0->10
        accept(8'd10);
        tick();
        chk("ab_p1", position, 1);
        repeat (4) tick();
        chk("ab_s2", step, 1);
        chk("ab_p2", position, 2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("ab_nodone", done, 0);
        tick();
        chk("ab_done", done, 1);
        chk("ab_pos", position, 2);
        chk("ab_ready", cmd_ready, 1);
        chk("ab_step", step, 0);

        // Abort in IDLE is ignored: 2->4 runs to completion
        tick();
        abort = 1'b1;
        tick();
        accept(8'd4);
        abort = 1'b0;
        repeat (5) tick();
        chk("ai_p", position, 4);
        chk("ai_nodone", done, 0);
        repeat (4) tick();
        chk("ai_done", done, 1);
        chk("ai_pos", position, 4);

        // Abort in SETUP still completes one full step: 4->8 stops at 5
        tick();
        accept(8'd8);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (4) tick();
        chk("as_done", done, 1);
        chk("as_pos", position, 5);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
